// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: state codes, opcodes,
// ALU/immediate/select codes, and the per-state control word.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word for a state; anything not set stays 0.
  function automatic ctrl_t ctrl_for(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.pc_update = 1'b1;
        c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR;
        c.alu_op = ALUOP_ADD; c.result_src = RES_ALURES;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_ADD;
      end
      S_MEMREAD:  begin c.result_src = RES_ALUOUT; c.adr_src = 1'b1; end
      S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      S_MEMWRITE: begin
        c.result_src = RES_ALUOUT; c.adr_src = 1'b1; c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
      S_BEQ: begin
        c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_op = ALUOP_SUB;
        c.result_src = RES_ALUOUT; c.branch = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.alu_op = ALUOP_ADD;
        c.result_src = RES_ALUOUT; c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] imm_src_for(logic [6:0] op);
    case (op)
      OP_STORE: return IMM_S;
      OP_BEQ:   return IMM_B;
      OP_JAL:   return IMM_J;
      default:  return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/status inputs and datapath control outputs of multicycle_ctrl.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero_flag;
  // mem_ready is a per-cycle completion strobe: a memory access issued in the
  // current cycle is complete when mem_ready=1 in that same cycle.
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALU_control;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7, Zero_flag, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALU_control, ImmSrc, RegWrite, illegal_op, state
  );

  modport slave (
    output op, funct3, funct7, Zero_flag, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALU_control, ImmSrc, RegWrite, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// Combinational ALU decoder: maps ALUop plus funct fields to ALU_control.
module mc_alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type sub from I-type addi, whose imm[10] aliases funct7
          3'b000:  alu_control = (funct7 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM. Define MEM_WAIT_EN to make FETCH, MEMREAD and
// MEMWRITE wait on mem_ready; otherwise each memory state takes one cycle.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  state_t state, next;
  ctrl_t  ctrl;
  logic   mem_ok;
  logic   in_mem_state;
  logic   advance;
  logic   legal;

`ifdef MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1 | bus.mem_ready;
`endif

  assign in_mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign advance      = !in_mem_state || mem_ok;

  assign legal = (bus.op == OP_LOAD) || (bus.op == OP_STORE) || (bus.op == OP_RTYPE) ||
                 (bus.op == OP_ITYPE) || (bus.op == OP_BEQ) || (bus.op == OP_JAL);

  always_comb begin
    next = state;
    case (state)
      S_FETCH:  next = advance ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_RTYPE:          next = S_EXECUTER;
          OP_ITYPE:          next = S_EXECUTEI;
          OP_BEQ:            next = S_BEQ;
          OP_JAL:            next = S_JAL;
          default:           next = S_FETCH;
        endcase
      end
      S_MEMADR:   next = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next = advance ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next = S_FETCH;
      S_MEMWRITE: next = advance ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: next = S_ALUWB;
      S_EXECUTEI: next = S_ALUWB;
      S_ALUWB:    next = S_FETCH;
      S_BEQ:      next = S_FETCH;
      S_JAL:      next = S_ALUWB;
      default:    next = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state so it always matches it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ctrl  <= ctrl_for(S_FETCH);
    end else begin
      state <= next;
      ctrl  <= ctrl_for(next);
    end
  end

  assign bus.PCWrite    = rst_n & ((ctrl.pc_update & advance) | (ctrl.branch & bus.Zero_flag));
  assign bus.IRWrite    = rst_n & ctrl.ir_write & advance;
  assign bus.MemWrite   = rst_n & ctrl.mem_write & advance;
  assign bus.RegWrite   = rst_n & ctrl.reg_write;
  assign bus.illegal_op = rst_n & (state == S_DECODE) & !legal;
  assign bus.AdrSrc     = ctrl.adr_src;
  assign bus.ResultSrc  = ctrl.result_src;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ImmSrc     = imm_src_for(bus.op);
  assign bus.state      = state;

  mc_alu_dec u_alu_dec (
    .alu_op      (ctrl.alu_op),
    .funct3      (bus.funct3),
    .funct7      (bus.funct7),
    .op5         (bus.op[5]),
    .alu_control (bus.ALU_control)
  );

endmodule
